// File: rtl/bp_pkg.sv
// Shared types and constants for the branch predictor feedback path.
package bp_pkg;

    localparam int BP_N  = 128;
    localparam int BHR_W = $clog2(BP_N);

    localparam logic [31:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [31:0]      pc;
        logic             pred_taken;
        logic [BHR_W-1:0] bhr;
    } brq_entry_t;

endpackage

// File: rtl/brq_storage.sv
// Entry array for the branch resolve queue: one write port, one async read port.
module brq_storage
    import bp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = $bits(brq_entry_t),
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    // Payloads carry no reset; pointers in the parent decide what is valid.
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches; resolves against execute outcomes,
// trains the global predictor and raises redirects on mispredicts.
module branch_resolve_queue
    import bp_pkg::*;
#(
    parameter int N     = BP_N,
    parameter int DEPTH = 4,
    localparam int HW   = $clog2(N),
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [31:0]   push_pc,
    input  logic          push_pred_taken,
    input  logic [HW-1:0] push_bhr,
    output logic          full,
    input  logic          resolve,
    input  logic          resolve_taken,
    input  logic [31:0]   resolve_target,
    output logic          is_branch_ex,
    output logic          cmp_out_ex,
    output logic [HW-1:0] bhr_ex,
    output logic          mispredict,
    output logic [31:0]   redirect_pc,
    output logic          err,
    output logic [31:0]   branch_cnt,
    output logic [31:0]   mispred_cnt
);

    // Same layout as brq_entry_t, with the history sized from N.
    typedef struct packed {
        logic [31:0]   pc;
        logic          pred_taken;
        logic [HW-1:0] bhr;
    } entry_t;

    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0] head, tail;
    logic [AW:0]   count;
    entry_t        wr_entry, head_entry;
    logic          res_ok, mis, push_ok, err_set;
    logic [31:0]   fix_pc;

    assign full     = (count == DEPTH_CNT);
    assign wr_entry = '{pc: push_pc, pred_taken: push_pred_taken, bhr: push_bhr};

    brq_storage #(.DEPTH(DEPTH), .W($bits(entry_t))) u_storage (
        .clk     (clk),
        .wr_en   (push_ok),
        .wr_addr (tail),
        .wr_data (wr_entry),
        .rd_addr (head),
        .rd_data (head_entry)
    );

    // A mispredicting resolve squashes a same-cycle push as wrong-path, so it is not an error.
    always_comb begin
        res_ok  = resolve && (count != '0);
        mis     = res_ok && (resolve_taken != head_entry.pred_taken);
        push_ok = push && !full && !mis;
        err_set = (push && full && !mis) || (resolve && (count == '0));
        fix_pc  = resolve_taken ? resolve_target : (head_entry.pc + PC_STEP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (mis) begin
            head  <= tail;
            count <= '0;
        end else begin
            if (push_ok) begin
                tail <= tail + AW'(1);
            end
            if (res_ok) begin
                head <= head + AW'(1);
            end
            count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, res_ok};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            is_branch_ex <= 1'b0;
            cmp_out_ex   <= 1'b0;
            bhr_ex       <= '0;
            mispredict   <= 1'b0;
            redirect_pc  <= '0;
        end else begin
            is_branch_ex <= res_ok;
            cmp_out_ex   <= res_ok && resolve_taken;
            bhr_ex       <= res_ok ? head_entry.bhr : '0;
            mispredict   <= mis;
            redirect_pc  <= mis ? fix_pc : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err         <= 1'b0;
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (err_set) begin
                err <= 1'b1;
            end
            if (res_ok && (branch_cnt != '1)) begin
                branch_cnt <= branch_cnt + 32'd1;
            end
            if (mis && (mispred_cnt != '1)) begin
                mispred_cnt <= mispred_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench for branch_resolve_queue: table vectors plus scoreboarded training outputs.
module tb_branch_resolve_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        push;
    logic [31:0] push_pc;
    logic        push_pred_taken;
    logic [6:0]  push_bhr;
    logic        full;
    logic        resolve;
    logic        resolve_taken;
    logic [31:0] resolve_target;
    logic        is_branch_ex;
    logic        cmp_out_ex;
    logic [6:0]  bhr_ex;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic        err;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    int compared = 0;
    int failed   = 0;

    typedef struct {
        logic [31:0] pc;
        logic        pred;
        logic [6:0]  bhr;
        logic        taken;
        logic [31:0] tgt;
        logic        exp_mis;
        logic [31:0] exp_redir;
    } vec_t;

    typedef struct {
        logic [6:0]  bhr;
        logic        taken;
        logic        mis;
        logic [31:0] redir;
    } exp_t;

    vec_t vecs[6];
    exp_t sb[$];

    branch_resolve_queue #(.N(128), .DEPTH(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .push            (push),
        .push_pc         (push_pc),
        .push_pred_taken (push_pred_taken),
        .push_bhr        (push_bhr),
        .full            (full),
        .resolve         (resolve),
        .resolve_taken   (resolve_taken),
        .resolve_target  (resolve_target),
        .is_branch_ex    (is_branch_ex),
        .cmp_out_ex      (cmp_out_ex),
        .bhr_ex          (bhr_ex),
        .mispredict      (mispredict),
        .redirect_pc     (redirect_pc),
        .err             (err),
        .branch_cnt      (branch_cnt),
        .mispred_cnt     (mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Training outputs are checked against the scoreboard whenever the DUT strobes them.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (is_branch_ex) begin
                if (sb.size() == 0) begin
                    compared++;
                    failed++;
                    $display("[TB] FAIL unexpected_train: got is_branch_ex=1 bhr_ex=0x%02h, expected no training at %0t", bhr_ex, $time);
                end else begin
                    e = sb.pop_front();
                    check_output("bhr_ex", 32'(bhr_ex), 32'(e.bhr));
                    check_output("cmp_out_ex", 32'(cmp_out_ex), 32'(e.taken));
                    check_output("mispredict", 32'(mispredict), 32'(e.mis));
                    if (e.mis) begin
                        check_output("redirect_pc", redirect_pc, e.redir);
                    end
                end
            end else if (mispredict) begin
                compared++;
                failed++;
                $display("[TB] FAIL stray_mispredict: got mispredict=1, expected 0 at %0t", $time);
            end
        end
    end

    // Called just after a rising edge; drives one cycle of inputs.
    task automatic drive(input logic p, input logic [31:0] pc, input logic pt, input logic [6:0] bhr,
                         input logic r, input logic rt, input logic [31:0] tgt);
        push            = p;
        push_pc         = pc;
        push_pred_taken = pt;
        push_bhr        = bhr;
        resolve         = r;
        resolve_taken   = rt;
        resolve_target  = tgt;
        @(posedge clk);
        #1;
        push    = 1'b0;
        resolve = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [31:0] pc, input logic pt, input logic [6:0] bhr);
        drive(1'b1, pc, pt, bhr, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic wait_drain();
        @(negedge clk);
        #1;
        check_output("sb_drain", 32'(sb.size()), 32'h0);
        @(posedge clk);
        #1;
    endtask

    task automatic resolve_one(input logic rt, input logic [31:0] tgt, input logic [6:0] ebhr,
                               input logic emis, input logic [31:0] eredir);
        sb.push_back('{bhr: ebhr, taken: rt, mis: emis, redir: eredir});
        drive(1'b0, 32'h0, 1'b0, 7'h0, 1'b1, rt, tgt);
        wait_drain();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        check_output("rst_is_branch_ex", 32'(is_branch_ex), 32'h0);
        check_output("rst_cmp_out_ex", 32'(cmp_out_ex), 32'h0);
        check_output("rst_bhr_ex", 32'(bhr_ex), 32'h0);
        check_output("rst_mispredict", 32'(mispredict), 32'h0);
        check_output("rst_redirect_pc", redirect_pc, 32'h0);
        check_output("rst_err", 32'(err), 32'h0);
        check_output("rst_full", 32'(full), 32'h0);
        check_output("rst_branch_cnt", branch_cnt, 32'h0);
        check_output("rst_mispred_cnt", mispred_cnt, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_mis;
        vecs[0] = '{32'h0000_1000, 1'b0, 7'h01, 1'b0, 32'h0000_5000, 1'b0, 32'h0};
        vecs[1] = '{32'h0000_0100, 1'b0, 7'h05, 1'b1, 32'h0000_0200, 1'b1, 32'h0000_0200};
        vecs[2] = '{32'h0000_0100, 1'b1, 7'h06, 1'b0, 32'h0000_0300, 1'b1, 32'h0000_0104};
        vecs[3] = '{32'h0000_2000, 1'b1, 7'h2A, 1'b1, 32'h0000_3000, 1'b0, 32'h0};
        vecs[4] = '{32'hFFFF_FFFC, 1'b1, 7'h7F, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[5] = '{32'h0000_0040, 1'b0, 7'h00, 1'b1, 32'hDEAD_BEE0, 1'b1, 32'hDEAD_BEE0};

        rst = 1'b0;
        push = 1'b0; push_pc = '0; push_pred_taken = 1'b0; push_bhr = '0;
        resolve = 1'b0; resolve_taken = 1'b0; resolve_target = '0;
        @(posedge clk);
        #1;
        do_reset();

        $display("[TB] three correctly predicted taken branches");
        apply_stimulus(32'h0000_0010, 1'b1, 7'h11);
        apply_stimulus(32'h0000_0020, 1'b1, 7'h22);
        apply_stimulus(32'h0000_0030, 1'b1, 7'h33);
        check_output("full_at_3", 32'(full), 32'h0);
        resolve_one(1'b1, 32'h0000_0800, 7'h11, 1'b0, 32'h0);
        resolve_one(1'b1, 32'h0000_0800, 7'h22, 1'b0, 32'h0);
        resolve_one(1'b1, 32'h0000_0800, 7'h33, 1'b0, 32'h0);
        check_output("branch_cnt_3", branch_cnt, 32'd3);
        check_output("mispred_cnt_0", mispred_cnt, 32'd0);

        $display("[TB] table vectors");
        n_mis = 0;
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(vecs[i].pc, vecs[i].pred, vecs[i].bhr);
            resolve_one(vecs[i].taken, vecs[i].tgt, vecs[i].bhr, vecs[i].exp_mis, vecs[i].exp_redir);
            check_output("vec_full", 32'(full), 32'h0);
            if (vecs[i].exp_mis) n_mis++;
        end
        check_output("branch_cnt_tbl", branch_cnt, 32'd9);
        check_output("mispred_cnt_tbl", mispred_cnt, 32'(n_mis));
        check_output("err_tbl", 32'(err), 32'h0);

        $display("[TB] fill, overflow, drain in order");
        for (int i = 1; i <= 4; i++) begin
            apply_stimulus(32'h0000_0400 + 32'(i * 4), 1'b0, 7'(i));
        end
        check_output("full_at_4", 32'(full), 32'h1);
        check_output("err_before_ovf", 32'(err), 32'h0);
        apply_stimulus(32'h0000_0500, 1'b0, 7'h05);
        check_output("err_after_ovf", 32'(err), 32'h1);
        check_output("full_after_ovf", 32'(full), 32'h1);
        for (int i = 1; i <= 4; i++) begin
            resolve_one(1'b0, 32'h0, 7'(i), 1'b0, 32'h0);
        end
        check_output("full_drained", 32'(full), 32'h0);
        check_output("branch_cnt_fill", branch_cnt, 32'd13);

        $display("[TB] push alongside resolves");
        do_reset();
        apply_stimulus(32'h0000_0800, 1'b1, 7'h08);
        apply_stimulus(32'h0000_0804, 1'b1, 7'h09);
        sb.push_back('{bhr: 7'h08, taken: 1'b0, mis: 1'b1, redir: 32'h0000_0804});
        drive(1'b1, 32'h0000_0900, 1'b1, 7'h55, 1'b1, 1'b0, 32'h0);
        wait_drain();
        check_output("err_wrong_path", 32'(err), 32'h0);
        check_output("full_after_flush", 32'(full), 32'h0);
        apply_stimulus(32'h0000_0A00, 1'b0, 7'h44);
        resolve_one(1'b0, 32'h0, 7'h44, 1'b0, 32'h0);
        apply_stimulus(32'h0000_0B00, 1'b1, 7'h10);
        sb.push_back('{bhr: 7'h10, taken: 1'b1, mis: 1'b0, redir: 32'h0});
        drive(1'b1, 32'h0000_0B10, 1'b1, 7'h11, 1'b1, 1'b1, 32'h0000_0C00);
        wait_drain();
        resolve_one(1'b1, 32'h0000_0C00, 7'h11, 1'b0, 32'h0);
        check_output("err_simul", 32'(err), 32'h0);
        check_output("branch_cnt_simul", branch_cnt, 32'd4);
        check_output("mispred_cnt_simul", mispred_cnt, 32'd1);

        $display("[TB] reset with entries queued");
        apply_stimulus(32'h0000_0D00, 1'b0, 7'h21);
        apply_stimulus(32'h0000_0D04, 1'b0, 7'h22);
        apply_stimulus(32'h0000_0D08, 1'b0, 7'h23);
        do_reset();
        drive(1'b0, 32'h0, 1'b0, 7'h0, 1'b1, 1'b0, 32'h0);
        check_output("no_train_empty", 32'(is_branch_ex), 32'h0);
        check_output("err_resolve_empty", 32'(err), 32'h1);
        check_output("branch_cnt_empty", branch_cnt, 32'd0);

        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

Tracks every predicted branch from fetch to execute and closes the loop with the global predictor. At fetch it records the predicted direction, PC and branch-history snapshot. At execute it pops the oldest entry, compares the prediction with the actual outcome and drives the predictor's training inputs (`is_branch_ex`, `cmp_out_ex`, `bhr_ex`). On a mispredict it raises a redirect/flush to the pipeline and discards all younger entries.

## Interface
Parameters:
- `N`, 128: predictor counter-table size; history width `n = $clog2(N)`.
- `DEPTH`, 4: queue entries (power of two, ≥ 2).

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-low reset.
- `push`  in  1  fetch issues a predicted branch this cycle.
- `push_pc`  in  32  branch PC.
- `push_pred_taken`  in  1  predicted direction (`glob_predict_taken`).
- `push_bhr`  in  n  history snapshot used for the prediction (`bhr_if`).
- `full`  out  1  `count == DEPTH`; fetch must stall branch issue.
- `resolve`  in  1  execute resolves the oldest branch.
- `resolve_taken`  in  1  actual outcome (comparator result).
- `resolve_target`  in  32  computed taken target.
- `is_branch_ex`  out  1  predictor training strobe.
- `cmp_out_ex`  out  1  training outcome.
- `bhr_ex`  out  n  training index (the stored snapshot).
- `mispredict`  out  1  one-cycle redirect pulse.
- `redirect_pc`  out  32  correct next PC, valid with `mispredict`.
- `err`  out  1  sticky: push while full, or resolve while empty.
- `branch_cnt`, `mispred_cnt`  out  32 each  saturating performance counters.

## Operation
- Circular FIFO with head/tail pointers of width `$clog2(DEPTH)` that wrap modulo DEPTH, plus a count of width `$clog2(DEPTH)+1`.
- Push is accepted iff `push && !full`. It writes `{pc, pred_taken, bhr}` at the tail.
- Push while full: dropped, sets `err`, pointers unchanged.
- Resolve is accepted iff `resolve && count != 0`. It pops the head and compares `resolve_taken` with the stored `pred_taken`.
- Resolve while empty: ignored, sets `err`, no training output.
- Every accepted resolve registers:
  - `is_branch_ex = 1`, `cmp_out_ex = resolve_taken`, `bhr_ex = entry.bhr`;
  - `branch_cnt` increments.
- On a mismatch it also registers:
  - `mispredict = 1`;
  - `redirect_pc = resolve_taken ? resolve_target : entry.pc + 4` (32-bit wrap);
  - `mispred_cnt` increments;
  - the queue empties (`head = tail`, `count = 0`) at the same edge.
- Simultaneous push and resolve:
  - If the resolve is correct, both occur and count is unchanged.
  - If the resolve mispredicts, the push is a wrong-path branch and is dropped without setting `err`.
- Counters saturate at `32'hFFFF_FFFF`.
- Reset (asynchronous, any time, including mid-flush) clears all of the following to 0:
  - pointers and count;
  - `is_branch_ex`, `cmp_out_ex`, `bhr_ex`;
  - `mispredict`, `redirect_pc`;
  - `err` and both counters.
  - Stored entry payloads need no reset.

## Timing
- `full` is combinational from the registered count. Push acceptance is decided on the same edge.
- Resolve to training/redirect outputs: exactly 1 cycle (registered). Each output is high for one cycle per accepted resolve.
- A push in cycle t can be resolved at earliest in cycle t+1. Entry data is readable the cycle after it is written.
- After a mispredict edge, `full = 0` in the next cycle and pushes are accepted immediately.
- `err` rises in the cycle after the offending event and holds until reset.

## Structure
- Shared package `bp_pkg`:
  - `brq_entry_t` struct `{logic [31:0] pc; logic pred_taken; logic [n-1:0] bhr;}`;
  - the `PC_STEP = 4` constant.
- Sub-module `brq_storage`: DEPTH-entry register array with one write port and one asynchronous read port (head). The top level holds the pointers, count, compare logic and output registers.

## Test plan
- Reset, then push 3 correct-taken branches (pred 1, actual 1) and resolve all 3. Expect `is_branch_ex` pulses with matching `bhr_ex`, `mispredict` never high, `branch_cnt = 3`, `mispred_cnt = 0`.
- Push pc=0x100 pred 0, then resolve taken with target 0x200. Expect `mispredict = 1` and `redirect_pc = 0x200` one cycle later, and count = 0.
- Push pc=0x100 pred 1, then resolve not-taken. Expect `redirect_pc = 0x104`.
- Push 4 entries. Expect `full = 1`; a 5th push sets `err`, and the following resolves return entries in order 1–4.
- Push while a mispredicting resolve occurs with 2 entries queued. Expect the queue empty, no `err`, and the next push accepted.
- Assert reset mid-stream with 3 entries queued. Expect all outputs at 0, `full = 0`; a subsequent resolve sets `err`.
